// File: rtl/yrv_stim_gen_if.sv
// Handshake/bus bundle for yrv_stim_gen: configuration in, request/port streams and status out.
interface yrv_stim_gen_if #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 16,
  parameter int N_PORTS = 2,
  parameter int DATA_W  = 16,
  parameter int RUN_W   = 32
);
  logic                              start;
  logic [RUN_W-1:0]                  run_len;
  logic [N_CH-1:0][CNT_W-1:0]        ch_period;
  logic [N_CH-1:0][CNT_W-1:0]        ch_width;
  logic [N_CH-1:0]                   ch_mode;
  logic [N_CH-1:0]                   ack;
  logic [N_CH-1:0]                   req;
  logic [N_CH-1:0]                   overrun;
  logic [N_PORTS-1:0][DATA_W-1:0]    port_data;
  logic                              busy;
  logic                              done;
  logic [RUN_W-1:0]                  cycle_cnt;

  modport master (output start, run_len, ch_period, ch_width, ch_mode, ack,
                  input  req, overrun, port_data, busy, done, cycle_cnt);
  modport slave  (input  start, run_len, ch_period, ch_width, ch_mode, ack,
                  output req, overrun, port_data, busy, done, cycle_cnt);
endinterface

// File: rtl/yrv_stim_gen.sv
// Stimulus generator: N_CH periodic pulse/level request channels plus N_PORTS data streams.
// Optional macro STIM_LFSR_EN: per-port 32-bit Galois LFSR streams (otherwise port_data is 0).
module yrv_stim_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load,
  input  logic             first,
  input  logic             step,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic             mode,
  input  logic             ack,
  output logic             req,
  output logic             overrun
);
  logic [CNT_W-1:0] per_q, wid_q, cnt_q, wc_q;
  logic [CNT_W-1:0] per_n, wid_n, cnt_n;
  logic             mode_q, mode_n, fire;

  // Config is used the same edge it is loaded, so cycle 0 can already fire.
  assign per_n  = load ? period : per_q;
  assign wid_n  = load ? width  : wid_q;
  assign mode_n = load ? mode   : mode_q;
  assign cnt_n  = (first || cnt_q == per_n - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
  assign fire   = step && (per_n != '0) && (cnt_n == per_n - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!resetb) begin
      per_q <= '0; wid_q <= '0; mode_q <= 1'b0;
      cnt_q <= '0; wc_q <= '0; req <= 1'b0; overrun <= 1'b0;
    end else begin
      if (load) begin
        per_q <= period; wid_q <= width; mode_q <= mode;
      end
      if (step) cnt_q <= cnt_n;
      overrun <= load ? 1'b0 : (overrun | (mode_q & fire & req));
      if (mode_n)
        req <= fire | (req & ~ack);
      else if (fire) begin
        req  <= 1'b1;
        wc_q <= (wid_n == '0) ? '0 : wid_n - CNT_W'(1);
      end else if (step && req && wc_q != '0)
        wc_q <= wc_q - CNT_W'(1);
      else
        req <= 1'b0;   // pulse ends, or forced low outside RUN
    end
  end
endmodule

module yrv_stim_gen #(
  parameter int          N_CH    = 2,
  parameter int          CNT_W   = 16,
  parameter int          N_PORTS = 2,
  parameter int          DATA_W  = 16,
  parameter int          RUN_W   = 32,
  parameter logic [31:0] SEED    = 32'h1
) (
  input logic            clk,
  input logic            resetb,
  yrv_stim_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_len_q;
  logic             load, first, last, step, busy_d, done_d;

  assign load  = (state == IDLE) && bus.start;
  assign first = load && (bus.run_len != '0);
  assign last  = (bus.cycle_cnt == run_len_q - RUN_W'(1));

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= IDLE; bus.busy <= 1'b0; bus.done <= 1'b0;
      bus.cycle_cnt <= '0; run_len_q <= '0;
    end else begin
      state    <= state_nxt;
      bus.busy <= busy_d;
      bus.done <= done_d;
      if (load) begin
        run_len_q     <= bus.run_len;
        bus.cycle_cnt <= '0;
      end else if (state == RUN && state_nxt == RUN)
        bus.cycle_cnt <= bus.cycle_cnt + RUN_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.run_len == '0) ? DRAIN : RUN;
      RUN:     if (last) state_nxt = DRAIN;
      DRAIN:   if (bus.req == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_nxt != IDLE);
    done_d = (state == DRAIN) && (state_nxt == IDLE);
    step   = first || (state == RUN && state_nxt == RUN);
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    yrv_stim_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .resetb  (resetb),
      .load    (load),
      .first   (first),
      .step    (step),
      .period  (bus.ch_period[c]),
      .width   (bus.ch_width[c]),
      .mode    (bus.ch_mode[c]),
      .ack     (bus.ack[c]),
      .req     (bus.req[c]),
      .overrun (bus.overrun[c])
    );
  end

`ifdef STIM_LFSR_EN
  logic adv;
  assign adv = (state == RUN) && (state_nxt == RUN);

  for (genvar p = 0; p < N_PORTS; p++) begin : g_lfsr
    localparam logic [31:0] S0 = 32'(SEED + p);
    localparam logic [31:0] S  = (S0 == 32'h0) ? 32'h1 : S0;
    logic [31:0] lfsr_q;
    always_ff @(posedge clk) begin
      if (!resetb)   lfsr_q <= '0;
      else if (load) lfsr_q <= S;
      else if (adv)  lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h80200003 : 32'h0);
    end
    assign bus.port_data[p] = lfsr_q[DATA_W-1:0];
  end
`else
  assign bus.port_data = '0;
`endif
endmodule

// File: tb/tb_yrv_stim_gen.sv
// Scenario bench for yrv_stim_gen: pulse/level channels, drain, mid-run reset, edges, port streams.
module tb_yrv_stim_gen;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  yrv_stim_gen_if sif ();
  yrv_stim_gen dut (.clk(clk), .resetb(resetb), .bus(sif));

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  // Drive config and a one-cycle start; returns at the negedge of RUN cycle 0.
  task automatic do_start(input int len, input int p0, input int p1,
                          input int w0, input int w1, input logic m0, input logic m1);
    sif.run_len      = 32'(len);
    sif.ch_period[0] = 16'(p0); sif.ch_period[1] = 16'(p1);
    sif.ch_width[0]  = 16'(w0); sif.ch_width[1]  = 16'(w1);
    sif.ch_mode      = {m1, m0};
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b0; tick(); tick();
    n_chk++; if (sif.req !== 2'b0) begin n_fail++; $display("FAIL reset_req: got %0h expected 0", sif.req); end
    n_chk++; if (sif.overrun !== 2'b0) begin n_fail++; $display("FAIL reset_overrun: got %0h expected 0", sif.overrun); end
    n_chk++; if (sif.port_data !== 32'h0) begin n_fail++; $display("FAIL reset_port: got %0h expected 0", sif.port_data); end
    n_chk++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", sif.busy); end
    n_chk++; if (sif.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", sif.done); end
    n_chk++; if (sif.cycle_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cycle: got %0d expected 0", sif.cycle_cnt); end
    resetb = 1'b1; tick();
  endtask

  task automatic test_pulse();
    int q0[$]; int q1[$]; int exp; int dones;
    for (int c = 99; c < 1000; c += 100) q0.push_back(c);
    for (int c = 332; c < 1000; c += 333) q1.push_back(c);
    do_start(1000, 100, 333, 1, 1, 1'b0, 1'b0);
    n_chk++; if (sif.busy !== 1'b1) begin n_fail++; $display("FAIL pulse_busy: got %0b expected 1", sif.busy); end
    dones = 0;
    for (int i = 0; i < 1100 && dones == 0; i++) begin
      if (sif.req[0] === 1'b1) begin
        exp = (q0.size() != 0) ? q0.pop_front() : -1;
        n_chk++; if (sif.cycle_cnt !== 32'(exp)) begin n_fail++; $display("FAIL pulse_ch0: req at cycle %0d expected %0d", sif.cycle_cnt, exp); end
      end
      if (sif.req[1] === 1'b1) begin
        exp = (q1.size() != 0) ? q1.pop_front() : -1;
        n_chk++; if (sif.cycle_cnt !== 32'(exp)) begin n_fail++; $display("FAIL pulse_ch1: req at cycle %0d expected %0d", sif.cycle_cnt, exp); end
      end
      if (sif.done === 1'b1) begin
        dones++;
        n_chk++; if (sif.cycle_cnt !== 32'd999) begin n_fail++; $display("FAIL pulse_done_cycle: got %0d expected 999", sif.cycle_cnt); end
      end
      tick();
    end
    n_chk++; if (dones != 1) begin n_fail++; $display("FAIL pulse_done_seen: got %0d expected 1", dones); end
    n_chk++; if (q0.size() + q1.size() != 0) begin n_fail++; $display("FAIL pulse_missing: got %0d unseen pulses expected 0", q0.size() + q1.size()); end
    n_chk++; if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin n_fail++; $display("FAIL pulse_after: busy %0b done %0b expected 0 0", sif.busy, sif.done); end
  endtask

  task automatic test_level();
    int q[$]; int exp; int hi;
    // Run A: ack 10 cycles after the rise.
    q.push_back(49);
    do_start(70, 50, 0, 1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 100 && sif.req[0] !== 1'b1; i++) tick();
    exp = q.pop_front();
    n_chk++; if (sif.cycle_cnt !== 32'(exp)) begin n_fail++; $display("FAIL level_rise: got %0d expected %0d", sif.cycle_cnt, exp); end
    hi = 0;
    for (int i = 0; i < 10; i++) begin if (sif.req[0] === 1'b1) hi++; tick(); end
    if (sif.req[0] === 1'b1) hi++;
    sif.ack[0] = 1'b1; tick(); sif.ack[0] = 1'b0;
    n_chk++; if (hi != 11) begin n_fail++; $display("FAIL level_high_len: got %0d expected 11", hi); end
    n_chk++; if (sif.req[0] !== 1'b0) begin n_fail++; $display("FAIL level_cleared: got %0b expected 0", sif.req[0]); end
    n_chk++; if (sif.overrun[0] !== 1'b0) begin n_fail++; $display("FAIL level_no_overrun: got %0b expected 0", sif.overrun[0]); end
    for (int i = 0; i < 40 && sif.done !== 1'b1; i++) tick();
    n_chk++; if (sif.done !== 1'b1) begin n_fail++; $display("FAIL level_a_done: got %0b expected 1", sif.done); end
    tick();
    // Run B: ack withheld, second fire at 99 overruns.
    do_start(120, 50, 0, 1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 98; i++) tick();
    n_chk++; if (sif.overrun[0] !== 1'b0 || sif.req[0] !== 1'b1) begin n_fail++; $display("FAIL level_pre_overrun: overrun %0b req %0b expected 0 1", sif.overrun[0], sif.req[0]); end
    tick();
    n_chk++; if (sif.overrun[0] !== 1'b1 || sif.cycle_cnt !== 32'd99) begin n_fail++; $display("FAIL level_overrun: overrun %0b at cycle %0d expected 1 at 99", sif.overrun[0], sif.cycle_cnt); end
    for (int i = 0; i < 40; i++) tick();
    n_chk++; if (sif.busy !== 1'b1 || sif.done !== 1'b0) begin n_fail++; $display("FAIL level_b_hold: busy %0b done %0b expected 1 0", sif.busy, sif.done); end
    sif.ack[0] = 1'b1; tick(); sif.ack[0] = 1'b0;
    tick();
    n_chk++; if (sif.done !== 1'b1 || sif.overrun[0] !== 1'b1) begin n_fail++; $display("FAIL level_b_done: done %0b overrun %0b expected 1 1", sif.done, sif.overrun[0]); end
    tick();
  endtask

  task automatic test_drain();
    int bad;
    do_start(10, 10, 0, 1, 1, 1'b1, 1'b0);
    n_chk++; if (sif.overrun !== 2'b0) begin n_fail++; $display("FAIL drain_overrun_clr: got %0h expected 0", sif.overrun); end
    for (int i = 0; i < 9; i++) tick();
    n_chk++; if (sif.req[0] !== 1'b1 || sif.cycle_cnt !== 32'd9) begin n_fail++; $display("FAIL drain_fire: req %0b cycle %0d expected 1 9", sif.req[0], sif.cycle_cnt); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sif.busy !== 1'b1 || sif.req[0] !== 1'b1 || sif.done !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL drain_hold: got %0d bad cycles expected 0", bad); end
    sif.ack[0] = 1'b1; tick(); sif.ack[0] = 1'b0;
    n_chk++; if (sif.req[0] !== 1'b0 || sif.done !== 1'b0) begin n_fail++; $display("FAIL drain_ack: req %0b done %0b expected 0 0", sif.req[0], sif.done); end
    tick();
    n_chk++; if (sif.done !== 1'b1 || sif.busy !== 1'b0) begin n_fail++; $display("FAIL drain_done: done %0b busy %0b expected 1 0", sif.done, sif.busy); end
    tick();
    n_chk++; if (sif.done !== 1'b0) begin n_fail++; $display("FAIL drain_done_pulse: got %0b expected 0", sif.done); end
  endtask

  task automatic test_mid_reset();
    do_start(1000, 100, 333, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) tick();
    n_chk++; if (sif.cycle_cnt !== 32'd500) begin n_fail++; $display("FAIL midrst_cycle: got %0d expected 500", sif.cycle_cnt); end
    resetb = 1'b0; tick();
    n_chk++; if ({sif.req, sif.overrun, sif.busy, sif.done} !== 6'b0 || sif.port_data !== 32'h0 || sif.cycle_cnt !== 32'h0) begin
      n_fail++; $display("FAIL midrst_zero: req %0h ovr %0h busy %0b done %0b port %0h cyc %0d expected all 0",
                         sif.req, sif.overrun, sif.busy, sif.done, sif.port_data, sif.cycle_cnt);
    end
    resetb = 1'b1; tick();
    test_pulse();
  endtask

  task automatic test_edges();
    int bad;
    // period 1 on ch0, period 0 on ch1.
    do_start(20, 1, 0, 1, 1, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sif.req[0] !== 1'b1 || sif.req[1] !== 1'b0) bad++;
      tick();
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL edge_period01: got %0d bad cycles expected 0", bad); end
    n_chk++; if (sif.req !== 2'b0) begin n_fail++; $display("FAIL edge_drain_req: got %0h expected 0", sif.req); end
    tick();
    n_chk++; if (sif.done !== 1'b1) begin n_fail++; $display("FAIL edge_p1_done: got %0b expected 1", sif.done); end
    tick();
    // run_len 0
    do_start(0, 1, 1, 1, 1, 1'b0, 1'b0);
    n_chk++; if (sif.busy !== 1'b1 || sif.done !== 1'b0 || sif.req !== 2'b0) begin n_fail++; $display("FAIL edge_len0_a: busy %0b done %0b req %0h expected 1 0 0", sif.busy, sif.done, sif.req); end
    tick();
    n_chk++; if (sif.done !== 1'b1 || sif.busy !== 1'b0 || sif.req !== 2'b0) begin n_fail++; $display("FAIL edge_len0_b: done %0b busy %0b req %0h expected 1 0 0", sif.done, sif.busy, sif.req); end
    tick();
    // start while busy
    do_start(30, 7, 0, 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    sif.run_len = 32'd5; sif.start = 1'b1; tick(); sif.start = 1'b0;
    n_chk++; if (sif.cycle_cnt !== 32'd11) begin n_fail++; $display("FAIL edge_busy_start: cycle %0d expected 11", sif.cycle_cnt); end
    for (int i = 0; i < 40 && sif.done !== 1'b1; i++) tick();
    n_chk++; if (sif.done !== 1'b1 || sif.cycle_cnt !== 32'd29) begin n_fail++; $display("FAIL edge_busy_len: done %0b cycle %0d expected 1 29", sif.done, sif.cycle_cnt); end
    tick();
  endtask

  task automatic test_lfsr();
    logic [15:0] q[$]; logic [15:0] exp;
`ifdef STIM_LFSR_EN
    q.push_back(16'h0001); q.push_back(16'h0003); q.push_back(16'h0002); q.push_back(16'h0001);
`else
    for (int i = 0; i < 4; i++) q.push_back(16'h0000);
`endif
    do_start(8, 0, 0, 1, 1, 1'b0, 1'b0);
`ifdef STIM_LFSR_EN
    exp = 16'h0002;
`else
    exp = 16'h0000;
`endif
    n_chk++; if (sif.port_data[1] !== exp) begin n_fail++; $display("FAIL lfsr_port1: got %0h expected %0h", sif.port_data[1], exp); end
    for (int i = 0; i < 4; i++) begin
      exp = q.pop_front();
      n_chk++; if (sif.port_data[0] !== exp) begin n_fail++; $display("FAIL lfsr_port0_c%0d: got %0h expected %0h", i, sif.port_data[0], exp); end
      tick();
    end
    for (int i = 0; i < 20 && sif.done !== 1'b1; i++) tick();
    tick();
  endtask

  initial begin
    sif.start = 1'b0; sif.run_len = '0; sif.ch_period = '0;
    sif.ch_width = '0; sif.ch_mode = '0; sif.ack = '0;
    test_reset();
    test_pulse();
    test_level();
    test_drain();
    test_mid_reset();
    test_edges();
    test_lfsr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
